watch_time_dp: RTL and testbench
================================

// Module: watch_time_dp
// PURPOSE
//  Timekeeping datapath for the watch. It sits directly downstream of the watch control unit.
//  It holds the msec/sec/min/hour counters and advances them from an internal 100 Hz tick.
//  It applies the control unit's single-cycle up/down adjust pulses to the selected field.
//  Its count outputs drive the FND display mux and the UART time reporter.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock frequency in Hz
//  TICK_HZ    100          msec-field tick rate; DIV = CLK_FREQ/TICK_HZ, must be >= 2
//  INIT_HOUR  12           hour value loaded on reset (0..23)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous reset, active-low
//  i_sec_up     in   1  1-cycle pulse: second field +1
//  i_sec_down   in   1  1-cycle pulse: second field -1
//  i_min_up     in   1  1-cycle pulse: minute field +1
//  i_min_down   in   1  1-cycle pulse: minute field -1
//  i_hour_up    in   1  1-cycle pulse: hour field +1
//  i_hour_down  in   1  1-cycle pulse: hour field -1
//  o_msec       out  7  centiseconds 0..99
//  o_sec        out  6  seconds 0..59
//  o_min        out  6  minutes 0..59
//  o_hour       out  5  hours 0..23
//  o_tick       out  1  1-cycle pulse, high in the cycle the msec field advances
// BEHAVIOUR
//  - Reset (rst_n=0, async): prescaler=0, o_tick=0, o_msec=0, o_sec=0, o_min=0, o_hour=INIT_HOUR.
//  - Prescaler counts 0..DIV-1 and wraps. o_tick is registered and is 1 for the cycle after count==DIV-1.
//  - On the edge where o_tick=1, msec increments.
//      99->0 carries into sec; sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0.
//      The full chain resolves on a single edge: 23:59:59.99 -> 00:00:00.00.
//  - Adjust pulses: all outputs are registered; the new value is visible the cycle after the pulse.
//      up: sec/min 59->0 and hour 23->0. down: sec/min 0->59 and hour 0->23.
//      Manual adjust never carries or borrows into a neighbouring field.
//  - i_sec_up/i_sec_down also clear msec and the prescaler to 0, so the adjusted second starts full.
//  - Both up and down for the same field in one cycle: up wins and down is ignored.
//  - Several fields adjusted in the same cycle: each applies independently.
//  - Adjust and tick-carry on the same field in the same edge: the adjust wins, and that field's carry-in is dropped.
//      Carries into the other fields still apply.
//      Example: sec=59, msec=99, tick, i_min_up -> sec=0, min=min+1 (only once), msec=0.
//  - Sec adjust and tick on the same edge: the msec/prescaler clear wins; no carry out of msec.
//  - Counter registers never hold out-of-range values. The sub-module asserts on out-of-range next state in sim only.
//  - Reset asserted mid-operation: all state returns to reset values immediately.
//      Counting resumes from the first edge with rst_n=1.
// STRUCTURE
//  - Shared include watch_defs.vh holds:
//      MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5
//      MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23
//  - Sub-module tick_gen #(CLK_FREQ,TICK_HZ): prescaler plus registered o_tick, with a sync clear input.
//  - Sub-module wrap_counter #(WIDTH,MAX,INIT): up/down/inc/clear inputs, wrap output.
//      Instantiated 4x; the carry chain and priority rules stay in watch_time_dp.
// TESTING  (sim with CLK_FREQ=1000, TICK_HZ=100 -> DIV=10)
//  1 Reset: rst_n=0 then release -> 12:00:00.00, o_tick=0; first o_tick after 10 clocks, msec=1 next.
//  2 Rollover: force 23:59:59.98, run 2 ticks -> 23:59:59.99 then 00:00:00.00 on one edge.
//  3 Adjust wrap: sec=59 + i_sec_up -> sec=0, min unchanged, msec=0; hour=0 + i_hour_down -> 23.
//  4 Collision: 10:20:59.99, i_min_up on the tick edge -> 10:21:00.00 (not :22).
//  5 Up+down: i_min_up and i_min_down together at min=30 -> 31; all six pulses at 05:05:05 -> 06:06:06.
//  6 Async reset mid-count: drop rst_n between edges at 01:02:03.45 -> outputs reset without a clock edge.

Source files
------------

// File: rtl/watch_time_dp_pkg.sv
// Shared field widths, field limits and prescaler helper for the watch time datapath.
package watch_time_dp_pkg;

  localparam int MSEC_W   = 7;
  localparam int SEC_W    = 6;
  localparam int MIN_W    = 6;
  localparam int HOUR_W   = 5;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Number of system clocks per msec-field tick.
  function automatic int calc_div(input int clk_freq, input int tick_hz);
    return clk_freq / tick_hz;
  endfunction

endpackage

// File: rtl/watch_time_dp_chk.sv
// Simulation-only range checker for a wrapping counter's next state.
module wrap_counter_chk #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input logic             clk,
  input logic             rst_n,
  input logic [WIDTH-1:0] cnt_nxt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // The value about to be loaded must always lie inside 0..MAX.
  a_nxt_in_range: assert property (@(posedge clk) disable iff (!rst_n) (cnt_nxt <= MAX_V));

endmodule

// File: rtl/watch_time_dp_tick_gen.sv
// Prescaler that emits a registered one-cycle tick every DIV clocks, with a sync clear.
module tick_gen
  import watch_time_dp_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, TICK_HZ);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST_V = CW'(DIV - 1);
  localparam logic [CW-1:0] ZERO_V = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tick_r;
  logic          tick_nxt_s;

  // Next prescaler value; a clear also suppresses a tick due on the same edge.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    tick_nxt_s = 1'b0;
    if (clr) begin
      cnt_nxt_s  = ZERO_V;
      tick_nxt_s = 1'b0;
    end else if (cnt_r == LAST_V) begin
      cnt_nxt_s  = ZERO_V;
      tick_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s  = cnt_r + ONE_V;
      tick_nxt_s = 1'b0;
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= ZERO_V;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= tick_nxt_s;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/watch_time_dp_wrap_counter.sv
// Modulo-(MAX+1) counter: clear > up > down > carry-in; wrap flags a carry-in rollover.
module wrap_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             up,
  input  logic             down,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             wrap_s;
  logic             at_max_s;
  logic             at_zero_s;

  assign at_max_s  = (cnt_r == MAX_V);
  assign at_zero_s = (cnt_r == ZERO_V);

  // Next value; manual adjust overrides and drops the carry-in, and never carries out.
  always_comb begin
    cnt_nxt_s = cnt_r;
    wrap_s    = 1'b0;
    if (clr) begin
      cnt_nxt_s = ZERO_V;
    end else if (up) begin
      cnt_nxt_s = at_max_s ? ZERO_V : (cnt_r + ONE_V);
    end else if (down) begin
      cnt_nxt_s = at_zero_s ? MAX_V : (cnt_r - ONE_V);
    end else if (inc) begin
      cnt_nxt_s = at_max_s ? ZERO_V : (cnt_r + ONE_V);
      wrap_s    = at_max_s;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= INIT_V;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt  = cnt_r;
  assign wrap = wrap_s;

  wrap_counter_chk #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_nxt (cnt_nxt_s)
  );

endmodule

// File: rtl/watch_time_dp.sv
// Watch timekeeping datapath: 100 Hz tick, msec/sec/min/hour carry chain and manual adjust.
module watch_time_dp
  import watch_time_dp_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_HZ   = 100,
  parameter int INIT_HOUR = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sec_up,
  input  logic              i_sec_down,
  input  logic              i_min_up,
  input  logic              i_min_down,
  input  logic              i_hour_up,
  input  logic              i_hour_down,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  logic sec_adj_s;
  logic tick_s;
  logic msec_wrap_s;
  logic sec_wrap_s;
  logic min_wrap_s;
  logic hour_wrap_unused_s;

  // A second adjust restarts the current second from zero: msec and prescaler both clear.
  assign sec_adj_s = i_sec_up | i_sec_down;

  tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sec_adj_s),
    .tick  (tick_s)
  );

  wrap_counter #(.WIDTH(MSEC_W), .MAX(MSEC_MAX), .INIT(0)) u_msec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sec_adj_s),
    .up    (1'b0),
    .down  (1'b0),
    .inc   (tick_s),
    .cnt   (o_msec),
    .wrap  (msec_wrap_s)
  );

  wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX), .INIT(0)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .up    (i_sec_up),
    .down  (i_sec_down),
    .inc   (msec_wrap_s),
    .cnt   (o_sec),
    .wrap  (sec_wrap_s)
  );

  wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX), .INIT(0)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .up    (i_min_up),
    .down  (i_min_down),
    .inc   (sec_wrap_s),
    .cnt   (o_min),
    .wrap  (min_wrap_s)
  );

  // Hour rollover has no consumer; the day simply restarts at 00.
  wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX), .INIT(INIT_HOUR)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .up    (i_hour_up),
    .down  (i_hour_down),
    .inc   (min_wrap_s),
    .cnt   (o_hour),
    .wrap  (hour_wrap_unused_s)
  );

  assign o_tick = tick_s;

endmodule

// File: tb/tb_watch_time_dp.sv
// Directed bench for watch_time_dp with DIV = 10 (CLK_FREQ=1000, TICK_HZ=100).
module tb_watch_time_dp;

  localparam logic [5:0] P_SU = 6'b100000;
  localparam logic [5:0] P_SD = 6'b010000;
  localparam logic [5:0] P_MU = 6'b001000;
  localparam logic [5:0] P_MD = 6'b000100;
  localparam logic [5:0] P_HU = 6'b000010;
  localparam logic [5:0] P_HD = 6'b000001;

  logic       clk;
  logic       rst_n;
  logic       sec_up, sec_down, min_up, min_down, hour_up, hour_down;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tick;

  int n_checks;
  int n_errors;

  watch_time_dp #(
    .CLK_FREQ  (1000),
    .TICK_HZ   (100),
    .INIT_HOUR (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sec_up    (sec_up),
    .i_sec_down  (sec_down),
    .i_min_up    (min_up),
    .i_min_down  (min_down),
    .i_hour_up   (hour_up),
    .i_hour_down (hour_down),
    .o_msec      (msec),
    .o_sec       (sec),
    .o_min       (min),
    .o_hour      (hour),
    .o_tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hms(input int h, input int m, input int s, input int ms);
    logic [23:0] v;
    v = {5'(h), 6'(m), 6'(s), 7'(ms)};
    return {8'd0, v};
  endfunction

  function automatic logic [31:0] now_t();
    return {8'd0, hour, min, sec, msec};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int ms);
    check_val(tag, now_t(), hms(h, m, s, ms));
  endtask

  // Called at a falling edge; drives the pulses across exactly one rising edge.
  task automatic pulse(input logic [5:0] mask);
    {sec_up, sec_down, min_up, min_down, hour_up, hour_down} = mask;
    @(negedge clk);
    {sec_up, sec_down, min_up, min_down, hour_up, hour_down} = 6'b000000;
  endtask

  task automatic pulse_n(input logic [5:0] mask, input int n);
    for (int i = 0; i < n; i++) pulse(mask);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    {sec_up, sec_down, min_up, min_down, hour_up, hour_down} = 6'b000000;

    // 1 Reset and first tick
    wait_clks(3);
    check_time("rst_hold_time", 12, 0, 0, 0);
    check_val("rst_hold_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    wait_clks(9);
    check_val("tick_not_yet", 32'(tick), 32'd0);
    check_time("pre_tick_time", 12, 0, 0, 0);
    wait_clks(1);
    check_val("first_tick", 32'(tick), 32'd1);
    check_val("first_tick_msec", 32'(msec), 32'd0);
    wait_clks(1);
    check_val("tick_one_cycle", 32'(tick), 32'd0);
    check_val("msec_after_tick", 32'(msec), 32'd1);

    // 2 Full rollover 23:59:59.99 -> 00:00:00.00
    pulse_n(P_HD, 13);
    pulse(P_MD);
    pulse(P_SD);
    check_time("set_235959", 23, 59, 59, 0);
    wait_clks(981);
    check_time("at_98", 23, 59, 59, 98);
    wait_clks(10);
    check_time("at_99", 23, 59, 59, 99);
    wait_clks(9);
    check_val("roll_tick", 32'(tick), 32'd1);
    check_time("roll_pre", 23, 59, 59, 99);
    wait_clks(1);
    check_time("rollover", 0, 0, 0, 0);

    // 3 Adjust wraps without carry/borrow
    pulse(P_SD);
    check_time("sec_down_0", 0, 0, 59, 0);
    pulse(P_SU);
    check_time("sec_up_59", 0, 0, 0, 0);
    pulse(P_HD);
    check_time("hour_down_0", 23, 0, 0, 0);
    pulse(P_HU);
    check_time("hour_up_23", 0, 0, 0, 0);
    pulse(P_HD);
    pulse(P_MD);
    check_time("min_down_0", 23, 59, 0, 0);
    pulse(P_MU);
    check_time("min_up_59", 23, 0, 0, 0);

    // 4 Adjust collides with tick carry
    pulse_n(P_HD, 13);
    pulse_n(P_MU, 20);
    pulse(P_SD);
    wait_clks(1000);
    check_val("coll_tick", 32'(tick), 32'd1);
    check_time("coll_pre", 10, 20, 59, 99);
    pulse(P_MU);
    check_time("collision", 10, 21, 0, 0);

    // 5 Up+down on one field, and all six together
    pulse_n(P_MU, 9);
    pulse(P_MU | P_MD);
    check_val("min_updown", 32'(min), 32'd31);
    pulse(P_SU | P_SD);
    check_time("sec_updown", 10, 31, 1, 0);
    pulse_n(P_HD, 5);
    pulse_n(P_MD, 26);
    pulse_n(P_SU, 4);
    check_time("set_050505", 5, 5, 5, 0);
    pulse(6'b111111);
    check_time("all_six", 6, 6, 6, 0);
    wait_clks(10);
    check_val("tick_before_sadj", 32'(tick), 32'd1);
    pulse(P_SU);
    check_time("sadj_on_tick", 6, 6, 7, 0);
    check_val("sadj_tick_low", 32'(tick), 32'd0);
    wait_clks(9);
    check_val("sadj_presc_clr", 32'(tick), 32'd0);
    check_val("sadj_msec_hold", 32'(msec), 32'd0);
    wait_clks(1);
    check_val("sadj_next_tick", 32'(tick), 32'd1);

    // 6 Async reset between edges
    pulse_n(P_HD, 5);
    pulse_n(P_MD, 4);
    pulse_n(P_SD, 4);
    wait_clks(451);
    check_time("set_010203_45", 1, 2, 3, 45);
    #2 rst_n = 1'b0;
    #1;
    check_time("async_rst_time", 12, 0, 0, 0);
    check_val("async_rst_tick", 32'(tick), 32'd0);
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(10);
    check_val("resume_tick", 32'(tick), 32'd1);
    wait_clks(1);
    check_time("resume_msec", 12, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
